// File: rtl/iterative_mul_div_unit_pkg.sv
// rtl/iterative_mul_div_unit_pkg.sv - shared types and helpers for the iterative multiply/divide unit
package iterative_mul_div_unit_pkg;

    // Widest XLEN the helper function below can describe.
    localparam int MUL_DIV_MAX_XLEN = 256;

    // One-hot operation select. Fields are declared last-to-first so that
    // op[0] = MUL, op[1] = MULH, ... op[7] = REMU.
    typedef struct packed {
        logic remu;
        logic rem;
        logic divu;
        logic div;
        logic mulhu;
        logic mulhsu;
        logic mulh;
        logic mul;
    } InstructionSetMulDiv;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } MulDivState;

    // Most-negative two's-complement value of an xlen-bit word, zero-extended
    // to MUL_DIV_MAX_XLEN bits; callers truncate to their own width.
    function automatic logic [MUL_DIV_MAX_XLEN-1:0] most_negative(input int xlen);
        logic [MUL_DIV_MAX_XLEN-1:0] one;
        one = {{(MUL_DIV_MAX_XLEN-1){1'b0}}, 1'b1};
        return one << (xlen - 1);
    endfunction

endpackage

// File: rtl/iterative_mul_div_unit_core.sv
// rtl/iterative_mul_div_unit_core.sv - per-step shift-add / restoring shift-subtract datapath
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             capture magnitudes and the operation kind; clears the high register
//   step             advance one iteration
//   is_div           1: restoring divide, 0: radix-2 multiply (sampled on load)
//   op_a, op_b       operand magnitudes (multiplicand/multiplier or dividend/divisor)
//   hi_next, lo_next value the registers take on the next step; multiply: product
//                    high/low halves, divide: remainder/quotient
module shift_add_sub_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] addend;
    logic            is_div_q;

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shifted;
    logic [XLEN:0] div_diff;

    always_comb begin
        // Multiply: conditionally add multiplicand into the high half, then
        // shift the whole 2*XLEN accumulator right, consuming one multiplier bit.
        mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
        // Divide: bring the next dividend bit into the partial remainder and
        // trial-subtract the divisor; bit XLEN of the difference is the borrow.
        div_shifted = {hi, lo[XLEN-1]};
        div_diff    = div_shifted - {1'b0, addend};

        hi_next = '0;
        lo_next = '0;
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                hi_next = div_diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            addend   <= '0;
            is_div_q <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= is_div ? op_a : op_b;
            addend   <= is_div ? op_b : op_a;
            is_div_q <= is_div;
        end else if (step) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/iterative_mul_div_unit.sv
// rtl/iterative_mul_div_unit.sv - multi-cycle RV32M-style multiply/divide unit with valid/ready handshake
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         request present
//   in_ready         unit can accept (state == IDLE)
//   op               one-hot operation: [0] MUL .. [7] REMU
//   reg1, reg2       rs1 / rs2 operands
//   flush            synchronous abort of in-flight or held result
//   out_valid        result present (state == DONE)
//   out_ready        consumer takes result
//   out              registered result
//   busy             state != IDLE
import iterative_mul_div_unit_pkg::*;

module iterative_mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int              CNT_W    = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_negative(XLEN));
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    MulDivState          state;
    logic [CNT_W-1:0]    counter;
    InstructionSetMulDiv op_in;
    InstructionSetMulDiv op_q;
    logic                neg_diff;   // operand signs differ: negate product / quotient
    logic                neg_a;      // dividend negative: negate remainder

    logic            op_valid;
    logic            in_div_op;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_by_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            accept;

    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_result;

    assign op_in     = op;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        op_valid  = $onehot(op_in);
        in_div_op = op_in.div | op_in.divu | op_in.rem | op_in.remu;
        sign_a    = (op_in.mul | op_in.mulh | op_in.mulhsu | op_in.div | op_in.rem) & reg1[XLEN-1];
        sign_b    = (op_in.mul | op_in.mulh | op_in.div | op_in.rem) & reg2[XLEN-1];
        abs_a     = sign_a ? -reg1 : reg1;
        abs_b     = sign_b ? -reg2 : reg2;

        div_by_zero = in_div_op && (reg2 == '0);
        sgn_ovf     = (op_in.div | op_in.rem) && (reg1 == MOST_NEG) && (reg2 == ALL_ONES);
        special     = div_by_zero | sgn_ovf;

        special_result = '0;
        if (div_by_zero) begin
            special_result = (op_in.div | op_in.divu) ? ALL_ONES : reg1;
        end else if (sgn_ovf) begin
            special_result = op_in.div ? reg1 : '0;
        end

        accept = (state == IDLE) && in_valid && op_valid && !flush;
    end

    shift_add_sub_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && !special),
        .step    ((state == CALC) && !flush),
        .is_div  (in_div_op),
        .op_a    (abs_a),
        .op_b    (abs_b),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign fix-up works on the core's next-step value so the result of the
    // final iteration is registered on the same edge that enters DONE.
    always_comb begin
        prod_fix = neg_diff ? -{hi_next, lo_next} : {hi_next, lo_next};
        quo_fix  = neg_diff ? -lo_next : lo_next;
        rem_fix  = neg_a    ? -hi_next : hi_next;

        calc_result = '0;
        if (op_q.mul) begin
            calc_result = prod_fix[XLEN-1:0];
        end else if (op_q.mulh | op_q.mulhsu | op_q.mulhu) begin
            calc_result = prod_fix[2*XLEN-1:XLEN];
        end else if (op_q.div | op_q.divu) begin
            calc_result = quo_fix;
        end else if (op_q.rem | op_q.remu) begin
            calc_result = rem_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            counter  <= '0;
            out      <= '0;
            op_q     <= '0;
            neg_diff <= 1'b0;
            neg_a    <= 1'b0;
        end else if (flush) begin
            // out keeps its last value; only the handshake state is dropped.
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_in;
                        neg_diff <= sign_a ^ sign_b;
                        neg_a    <= sign_a;
                        if (special) begin
                            out   <= special_result;
                            state <= DONE;
                        end else begin
                            counter <= CNT_W'(XLEN);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        out   <= calc_result;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// tb/tb_iterative_mul_div_unit.sv - scoreboard bench for iterative_mul_div_unit
module tb_iterative_mul_div_unit;

    localparam logic [7:0] OP_MUL    = 8'h01;
    localparam logic [7:0] OP_MULH   = 8'h02;
    localparam logic [7:0] OP_MULHSU = 8'h04;
    localparam logic [7:0] OP_MULHU  = 8'h08;
    localparam logic [7:0] OP_DIV    = 8'h10;
    localparam logic [7:0] OP_DIVU   = 8'h20;
    localparam logic [7:0] OP_REM    = 8'h40;
    localparam logic [7:0] OP_REMU   = 8'h80;
    localparam int         NORM_LAT  = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  op = 8'h00;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    iterative_mul_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .reg1      (reg1),
        .reg2      (reg2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        logic is_div;
        is_div = (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
        return (is_div && b == 32'd0) ||
               ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu, pv;
        int          ia, ib;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ub = $signed({32'h0, b});
        ia = a;
        ib = b;
        case (o)
            OP_MUL:    begin p = sa * sb; pv = p; return pv[31:0]; end
            OP_MULH:   begin p = sa * sb; pv = p; return pv[63:32]; end
            OP_MULHSU: begin p = sa * ub; pv = p; return pv[63:32]; end
            OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: every completed handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", {63'h0, out_valid}, 64'h0);
            else check("result", {32'h0, out}, {32'h0, exp_q.pop_front()});
        end
    end

    task automatic accept(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready_pre", {63'h0, in_ready}, 64'h1);
        op = o; reg1 = a; reg2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 8'h00;
    endtask

    task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        exp_q.push_back(exp);
        accept(o, a, b);
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
            else busy_ok = busy_ok & busy;
        end
        check("latency", lat, exp_lat);
        check("busy_during", {63'h0, busy_ok}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ops[8];
        logic [7:0]  o;
        logic [31:0] a, b;
        logic        seen;
        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check("reset_out", {32'h0, out}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_in_ready", {63'h0, in_ready}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT);
        run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, NORM_LAT);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM_LAT);
        run_op(OP_DIV,    -32'sd7,        32'd2,         32'hFFFF_FFFD, NORM_LAT);
        run_op(OP_REM,    -32'sd7,        32'd2,         32'hFFFF_FFFF, NORM_LAT);
        run_op(OP_DIVU,   32'd100,        32'd7,         32'd14,        NORM_LAT);
        run_op(OP_REMU,   32'd100,        32'd7,         32'd2,         NORM_LAT);
        run_op(OP_REM,    32'd7,          -32'sd2,       32'd1,         NORM_LAT);
        run_op(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op(OP_REMU,   32'd5,          32'd0,         32'd5,         1);
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        for (int i = 0; i < 16; i++) begin
            o = ops[$urandom_range(0, 7)];
            a = $urandom();
            b = (i % 5 == 0) ? 32'd0 : $urandom();
            if (i % 4 == 1) b = b >> $urandom_range(0, 28);
            run_op(o, a, b, model(o, a, b), is_special(o, a, b) ? 1 : NORM_LAT);
        end

        // Non-one-hot ops are ignored.
        @(negedge clk);
        op = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        op = 8'h11;
        @(negedge clk);
        in_valid = 1'b0; op = 8'h00;
        check("invalid_op_busy", {63'h0, busy}, 64'h0);
        check("invalid_op_valid", {63'h0, out_valid}, 64'h0);

        // Back-pressure in DONE.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_LAT);
        repeat (5) begin
            @(negedge clk);
            check("bp_out", {32'h0, out}, 64'd14);
            check("bp_out_valid", {63'h0, out_valid}, 64'h1);
            check("bp_in_ready", {63'h0, in_ready}, 64'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", {63'h0, in_ready}, 64'h1);
        run_op(OP_MUL, 32'd9, 32'd11, 32'd99, NORM_LAT);

        // Flush on CALC cycle 10.
        accept(OP_MUL, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {63'h0, in_ready}, 64'h1);
        check("flush_out_hold", {32'h0, out}, 64'd99);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("flush_no_valid", {63'h0, seen}, 64'h0);

        // Flush in the accept cycle drops the request.
        @(negedge clk);
        op = OP_MUL; reg1 = 32'd2; reg2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0; op = 8'h00;
        @(negedge clk);
        check("flush_accept_busy", {63'h0, busy}, 64'h0);
        check("flush_accept_in_ready", {63'h0, in_ready}, 64'h1);

        // Asynchronous reset mid-CALC.
        accept(OP_MUL, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("async_rst_out", {32'h0, out}, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, NORM_LAT);

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
